// File: rtl/cpu_types_pkg.sv
// Shared MIPS core types: opcode/funct/ALU encodings plus the decode-stage
// control bundle, instruction-queue entry and decoded output-slot record.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    JAL   = 6'h03,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    ADDI  = 6'h08,
    ADDIU = 6'h09,
    SLTI  = 6'h0a,
    SLTIU = 6'h0b,
    ANDI  = 6'h0c,
    ORI   = 6'h0d,
    XORI  = 6'h0e,
    LUI   = 6'h0f,
    LW    = 6'h23,
    SW    = 6'h2b,
    HALT  = 6'h3f
  } opcode_t;

  typedef enum logic [5:0] {
    SLL  = 6'h00,
    SRL  = 6'h02,
    JR   = 6'h08,
    ADD  = 6'h20,
    ADDU = 6'h21,
    SUB  = 6'h22,
    SUBU = 6'h23,
    AND  = 6'h24,
    OR   = 6'h25,
    XOR  = 6'h26,
    NOR  = 6'h27,
    SLT  = 6'h2a,
    SLTU = 6'h2b
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'b0000,
    ALU_SRL  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_NOR  = 4'b0111,
    ALU_SLT  = 4'b1010,
    ALU_SLTU = 4'b1011
  } aluop_t;

  // regdst:   0 rt, 1 rd, 2 $ra
  // pc_src:   0 npc, 1 branch target, 2 jump target, 3 register (JR)
  // memtoreg: 0 ALU, 1 memory, 2 npc (link), 3 upper immediate (LUI)
  // extop:    1 sign-extend immediate, 0 zero-extend
  typedef struct packed {
    opcode_t    opcode;
    funct_t     funct;
    logic [1:0] regdst;
    logic       alu_src;
    logic [1:0] pc_src;
    logic [1:0] memtoreg;
    logic       regwr;
    logic       memwr;
    logic       dcuREN;
    logic       dcuWEN;
    logic       extop;
    aluop_t     alu_op;
    logic       halt;
  } decode_ctrl_t;

  typedef struct packed {
    word_t instr;
    word_t npc;
  } iq_entry_t;

  // Everything the output slot registers for one decoded instruction.
  typedef struct packed {
    decode_ctrl_t ctrl;
    regbits_t     rs;
    regbits_t     rt;
    regbits_t     rd;
    regbits_t     shamt;
    word_t        imm32;
    word_t        npc;
  } dec_slot_t;

endpackage

// File: rtl/pipeline_decode_unit_if.sv
// Fetch-side and execute-side handshake bundle for pipeline_decode_unit.
// slave = decode stage view, master = surrounding pipeline view.
interface pipeline_decode_unit_if;
  import cpu_types_pkg::*;

  logic         if_valid;
  logic         if_ready;
  word_t        if_instr;
  word_t        if_npc;

  logic         ex_valid;
  logic         ex_ready;
  decode_ctrl_t ex_ctrl;
  regbits_t     ex_rs;
  regbits_t     ex_rt;
  regbits_t     ex_rd;
  regbits_t     ex_shamt;
  word_t        ex_imm32;
  word_t        ex_npc;

  modport slave (
    input  if_valid, if_instr, if_npc, ex_ready,
    output if_ready, ex_valid, ex_ctrl, ex_rs, ex_rt, ex_rd, ex_shamt,
           ex_imm32, ex_npc
  );

  modport master (
    output if_valid, if_instr, if_npc, ex_ready,
    input  if_ready, ex_valid, ex_ctrl, ex_rs, ex_rt, ex_rd, ex_shamt,
           ex_imm32, ex_npc
  );

endinterface

// File: rtl/instr_decoder.sv
// Combinational MIPS control decode: instruction word -> control bundle.
// Encodings match the single-cycle control unit.
module instr_decoder
  import cpu_types_pkg::*;
(
  input  word_t        instr,
  output decode_ctrl_t ctrl
);

  opcode_t op;
  funct_t  fn;
  logic    unused_fields;

  assign op = opcode_t'(instr[31:26]);
  assign fn = funct_t'(instr[5:0]);
  // register/immediate fields are extracted by the stage, not here
  assign unused_fields = ^instr[25:6];

  // opcode/funct -> control; unknown encodings leave every enable low
  always_comb begin
    ctrl        = '0;
    ctrl.opcode = op;
    ctrl.funct  = fn;
    ctrl.alu_op = ALU_ADD;
    ctrl.extop  = 1'b1;
    case (op)
      RTYPE: begin
        ctrl.regdst = 2'd1;
        ctrl.regwr  = 1'b1;
        case (fn)
          SLL:       ctrl.alu_op = ALU_SLL;
          SRL:       ctrl.alu_op = ALU_SRL;
          ADD, ADDU: ctrl.alu_op = ALU_ADD;
          SUB, SUBU: ctrl.alu_op = ALU_SUB;
          AND:       ctrl.alu_op = ALU_AND;
          OR:        ctrl.alu_op = ALU_OR;
          XOR:       ctrl.alu_op = ALU_XOR;
          NOR:       ctrl.alu_op = ALU_NOR;
          SLT:       ctrl.alu_op = ALU_SLT;
          SLTU:      ctrl.alu_op = ALU_SLTU;
          JR: begin
            ctrl.regwr  = 1'b0;
            ctrl.pc_src = 2'd3;
          end
          default:   ctrl.regwr  = 1'b0;
        endcase
      end
      J:   ctrl.pc_src = 2'd2;
      JAL: begin
        ctrl.pc_src   = 2'd2;
        ctrl.regdst   = 2'd2;
        ctrl.memtoreg = 2'd2;
        ctrl.regwr    = 1'b1;
      end
      BEQ, BNE: begin
        ctrl.pc_src = 2'd1;
        ctrl.alu_op = ALU_SUB;
      end
      ADDI, ADDIU: begin
        ctrl.alu_src = 1'b1;
        ctrl.regwr   = 1'b1;
      end
      SLTI: begin
        ctrl.alu_src = 1'b1;
        ctrl.regwr   = 1'b1;
        ctrl.alu_op  = ALU_SLT;
      end
      SLTIU: begin
        ctrl.alu_src = 1'b1;
        ctrl.regwr   = 1'b1;
        ctrl.alu_op  = ALU_SLTU;
      end
      ANDI: begin
        ctrl.alu_src = 1'b1;
        ctrl.regwr   = 1'b1;
        ctrl.extop   = 1'b0;
        ctrl.alu_op  = ALU_AND;
      end
      ORI: begin
        ctrl.alu_src = 1'b1;
        ctrl.regwr   = 1'b1;
        ctrl.extop   = 1'b0;
        ctrl.alu_op  = ALU_OR;
      end
      XORI: begin
        ctrl.alu_src = 1'b1;
        ctrl.regwr   = 1'b1;
        ctrl.extop   = 1'b0;
        ctrl.alu_op  = ALU_XOR;
      end
      LUI: begin
        ctrl.alu_src  = 1'b1;
        ctrl.regwr    = 1'b1;
        ctrl.extop    = 1'b0;
        ctrl.memtoreg = 2'd3;
      end
      LW: begin
        ctrl.alu_src  = 1'b1;
        ctrl.regwr    = 1'b1;
        ctrl.dcuREN   = 1'b1;
        ctrl.memtoreg = 2'd1;
      end
      SW: begin
        ctrl.alu_src = 1'b1;
        ctrl.memwr   = 1'b1;
        ctrl.dcuWEN  = 1'b1;
      end
      HALT:    ctrl.halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_decode_unit.sv
// Pipelined decode stage: DEPTH-entry instruction queue feeding one
// registered output slot with valid/ready handshake, flush and sticky halt.
// Optional load-use interlock when DECODE_HAZARD_EN is defined.
module pipeline_decode_unit
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  flush,
  pipeline_decode_unit_if.slave bus,
  output logic                  hazard_stall,
  output logic                  halt
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;

  iq_entry_t          mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ex_valid_q, ex_valid_d;
  dec_slot_t          slot_q, slot_d;
  logic               halt_seen_q, halt_seen_d;
  logic               halt_q, halt_d;

  iq_entry_t          head;
  decode_ctrl_t       dec_ctrl;
  dec_slot_t          head_slot;
  logic               full, empty, push, issue, hazard;

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  instr_decoder u_dec (
    .instr (head.instr),
    .ctrl  (dec_ctrl)
  );

  // decoded head, ready to drop into the output slot
  always_comb begin
    head_slot.ctrl  = dec_ctrl;
    head_slot.rs    = head.instr[25:21];
    head_slot.rt    = head.instr[20:16];
    head_slot.rd    = head.instr[15:11];
    head_slot.shamt = head.instr[10:6];
    head_slot.imm32 = dec_ctrl.extop ? {{16{head.instr[15]}}, head.instr[15:0]}
                                     : {16'h0000, head.instr[15:0]};
    head_slot.npc   = head.npc;
  end

`ifdef DECODE_HAZARD_EN
  logic head_uses_rt;

  // a load in the slot whose target feeds the head's source operands
  always_comb begin
    head_uses_rt = (dec_ctrl.opcode == RTYPE) || (dec_ctrl.opcode == BEQ) ||
                   (dec_ctrl.opcode == BNE)   || (dec_ctrl.opcode == SW);
    hazard = ex_valid_q && slot_q.ctrl.dcuREN && (slot_q.rt != '0) &&
             ((slot_q.rt == head_slot.rs) ||
              (head_uses_rt && (slot_q.rt == head_slot.rt)));
  end
  assign hazard_stall = hazard && !empty;
`else
  assign hazard       = 1'b0;
  assign hazard_stall = 1'b0;
`endif

  // flush and halt both close the fetch side; a full queue never bypasses
  assign bus.if_ready = !full && !halt_seen_q && !flush;
  assign push         = bus.if_valid && bus.if_ready;
  assign issue        = !empty && (!ex_valid_q || bus.ex_ready) && !hazard &&
                        !halt_seen_q && !flush;

  // queue storage holds data only; occupancy lives in count_q
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= '{instr: bus.if_instr, npc: bus.if_npc};
  end

  // next-state: flush beats push/issue; halt is only cleared by reset
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ex_valid_d  = ex_valid_q;
    slot_d      = slot_q;
    halt_seen_d = halt_seen_q;
    halt_d      = halt_q || (ex_valid_q && bus.ex_ready && slot_q.ctrl.halt);
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ex_valid_d = 1'b0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + PW'(1);
      if (issue) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(issue);
      if (issue) begin
        ex_valid_d  = 1'b1;
        slot_d      = head_slot;
        halt_seen_d = halt_seen_q || dec_ctrl.halt;
      end else if (ex_valid_q && bus.ex_ready) begin
        ex_valid_d = 1'b0;
      end
    end
  end

  // state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ex_valid_q  <= 1'b0;
      slot_q      <= '0;
      halt_seen_q <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ex_valid_q  <= ex_valid_d;
      slot_q      <= slot_d;
      halt_seen_q <= halt_seen_d;
      halt_q      <= halt_d;
    end
  end

  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_ctrl  = slot_q.ctrl;
  assign bus.ex_rs    = slot_q.rs;
  assign bus.ex_rt    = slot_q.rt;
  assign bus.ex_rd    = slot_q.rd;
  assign bus.ex_shamt = slot_q.shamt;
  assign bus.ex_imm32 = slot_q.imm32;
  assign bus.ex_npc   = slot_q.npc;
  assign halt         = halt_q;

endmodule

// File: tb/tb_pipeline_decode_unit.sv
// Directed bench for pipeline_decode_unit (DEPTH=4).
module tb_pipeline_decode_unit;
  import cpu_types_pkg::*;

  logic clk, nrst, flush, hazard_stall, halt;
  int   tests = 0;
  int   fails = 0;
  int   acc;

  pipeline_decode_unit_if bus();

  pipeline_decode_unit #(.DEPTH(4)) dut (
    .CLK          (clk),
    .nRST         (nrst),
    .flush        (flush),
    .bus          (bus),
    .hazard_stall (hazard_stall),
    .halt         (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input word_t ins, input word_t npc);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_npc   = npc;
  endtask

  initial begin
    nrst = 1'b0;
    flush = 1'b0;
    bus.ex_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    // reset
    repeat (3) @(posedge clk);
    #2;
    nrst = 1'b1;
    #1;
    chk("rst_if_ready", 32'(bus.if_ready), 32'd1);
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_hazard", 32'(hazard_stall), 32'd0);
    chk("rst_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
    chk("rst_ex_rt", 32'(bus.ex_rt), 32'd0);
    chk("rst_ex_imm", bus.ex_imm32, 32'd0);
    chk("rst_ex_npc", bus.ex_npc, 32'd0);

    // basic ORI decode and two-edge latency
    tick();
    bus.ex_ready = 1'b1;
    drive(1'b1, 32'h340100FF, 32'h00000104);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("ori_not_yet", 32'(bus.ex_valid), 32'd0);
    tick();
    chk("ori_valid", 32'(bus.ex_valid), 32'd1);
    chk("ori_regwr", 32'(bus.ex_ctrl.regwr), 32'd1);
    chk("ori_alu_src", 32'(bus.ex_ctrl.alu_src), 32'd1);
    chk("ori_alu_op", 32'(bus.ex_ctrl.alu_op), 32'(ALU_OR));
    chk("ori_extop", 32'(bus.ex_ctrl.extop), 32'd0);
    chk("ori_rt", 32'(bus.ex_rt), 32'd1);
    chk("ori_imm", bus.ex_imm32, 32'h000000FF);
    chk("ori_npc", bus.ex_npc, 32'h00000104);
    tick();
    chk("ori_drained", 32'(bus.ex_valid), 32'd0);

    // fill with ex_ready low: 1 in slot + 4 queued, 6th refused
    bus.ex_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h24000000 + 32'(i + 1), 32'h200 + 32'(4 * i));
      #1;
      if (bus.if_ready) acc++;
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
    #1;
    chk("fill_accepted", 32'(acc), 32'd5);
    chk("fill_if_ready", 32'(bus.if_ready), 32'd0);
    chk("fill_head_imm", bus.ex_imm32, 32'd1);
    bus.ex_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_valid", 32'(bus.ex_valid), 32'd1);
      chk("drain_imm", bus.ex_imm32, 32'(k + 1));
      chk("drain_npc", bus.ex_npc, 32'h200 + 32'(4 * k));
      tick();
    end
    chk("drain_empty", 32'(bus.ex_valid), 32'd0);

    // load-use: LW $2,0($1) then ADDU $3,$2,$2
    drive(1'b1, 32'h8C220000, 32'h300);
    tick();
    drive(1'b1, 32'h00421821, 32'h304);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("lw_valid", 32'(bus.ex_valid), 32'd1);
    chk("lw_dcuREN", 32'(bus.ex_ctrl.dcuREN), 32'd1);
    chk("lw_rt", 32'(bus.ex_rt), 32'd2);
`ifdef DECODE_HAZARD_EN
    chk("lu_stall", 32'(hazard_stall), 32'd1);
`else
    chk("lu_stall", 32'(hazard_stall), 32'd0);
`endif
    tick();
`ifdef DECODE_HAZARD_EN
    chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
    chk("lu_stall_clear", 32'(hazard_stall), 32'd0);
    tick();
`endif
    chk("addu_valid", 32'(bus.ex_valid), 32'd1);
    chk("addu_rd", 32'(bus.ex_rd), 32'd3);
    chk("addu_alu_op", 32'(bus.ex_ctrl.alu_op), 32'(ALU_ADD));
    chk("addu_regdst", 32'(bus.ex_ctrl.regdst), 32'd1);
    tick();
    chk("lu_done", 32'(bus.ex_valid), 32'd0);

    // flush: slot + 3 queued are squashed
    bus.ex_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h24000011 + 32'(i), 32'h400 + 32'(4 * i));
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
    chk("pre_flush_valid", 32'(bus.ex_valid), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_blocks_push", 32'(bus.if_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_if_ready", 32'(bus.if_ready), 32'd1);
    bus.ex_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flushed_gone", 32'(bus.ex_valid), 32'd0);
    end
    drive(1'b1, 32'h34010077, 32'h500);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("post_flush_valid", 32'(bus.ex_valid), 32'd1);
    chk("post_flush_imm", bus.ex_imm32, 32'h77);
    tick();

    // halt: HALT then ORI; ORI must never issue
    drive(1'b1, 32'hFFFFFFFF, 32'h600);
    tick();
    drive(1'b1, 32'h34010055, 32'h604);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    #1;
    chk("halt_slot_valid", 32'(bus.ex_valid), 32'd1);
    chk("halt_slot_ctrl", 32'(bus.ex_ctrl.halt), 32'd1);
    chk("halt_before_hs", 32'(halt), 32'd0);
    chk("halt_if_ready", 32'(bus.if_ready), 32'd0);
    tick();
    chk("halt_set", 32'(halt), 32'd1);
    chk("halt_no_ori", 32'(bus.ex_valid), 32'd0);
    repeat (3) tick();
    chk("halt_sticky", 32'(halt), 32'd1);
    chk("halt_still_no_ori", 32'(bus.ex_valid), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("halt_after_flush", 32'(halt), 32'd1);
    chk("halt_flush_if_ready", 32'(bus.if_ready), 32'd0);

    // asynchronous reset mid-cycle clears halt and reopens fetch
    nrst = 1'b0;
    #1;
    chk("areset_halt", 32'(halt), 32'd0);
    chk("areset_if_ready", 32'(bus.if_ready), 32'd1);
    nrst = 1'b1;
    tick();
    drive(1'b1, 32'h34010033, 32'h700);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("post_reset_valid", 32'(bus.ex_valid), 32'd1);
    chk("post_reset_imm", bus.ex_imm32, 32'h33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
